// File: rtl/spram_ctrl_pkg.sv
// Shared definitions for the single-port RAM access controller.
//   - Grant encodings driven by the arbiter each cycle.
//   - Round-robin pointer encoding (which channel wins the next contest).
//   - Response record layout {err, data}; width helper below.
// Optional build macro used by the controller: SPRAM_CTRL_WR_PRIO_EN.
package spram_ctrl_pkg;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_WR   = 2'd1;
    localparam logic [1:0] GNT_RD   = 2'd2;

    typedef enum logic {
        RrWr = 1'b0,
        RrRd = 1'b1
    } rr_ptr_e;

    // Response record: err flag in the MSB, read data below it.
    function automatic int unsigned rsp_rec_w(input int unsigned data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/spram_rsp_fifo.sv
// Small synchronous FIFO buffering read responses.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   push_i/data_i write side; a push while full is only taken with a same-cycle pop
//   pop_i/data_o  read side; data_o shows the head entry
//   full_o, empty_o, count_o  occupancy status
module spram_rsp_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 9,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] LastIdx = PtrW'(Depth - 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/spram_access_ctrl.sv
// Request front-end for a single-port RAM (registered read address, combinational q).
// Arbitrates a write and a read request channel onto the RAM pins, captures q one cycle
// after each read issue and returns it in order on a back-pressurable response channel.
// Out-of-range addresses (>= DEPTH) never write and return an error response with data 0.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   wr_valid/wr_ready/wr_addr/wr_data write request channel
//   rd_valid/rd_ready/rd_addr        read request channel
//   rsp_valid/rsp_ready/rsp_data/rsp_err  read response channel
//   ram_data/ram_addr/ram_we/ram_q   RAM interface
// Build macro: SPRAM_CTRL_WR_PRIO_EN -> writes always win a contest (no round-robin).
module spram_access_ctrl
    import spram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int unsigned RecW = rsp_rec_w(DATA_W);
    localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);
    localparam int unsigned OccW = CntW + 1;
    localparam logic [ADDR_W:0] AddrLimit = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        gnt;
    logic              grant_wr, grant_rd;
    logic              elig_wr, elig_rd;
    logic              wr_oor, rd_oor;
    logic              rd_credit;
    logic [OccW-1:0]   occ;
    logic              push, pop;
    logic [RecW-1:0]   fifo_wdata, fifo_rdata;
    logic              fifo_full, fifo_empty;
    logic [CntW-1:0]   fifo_count;
    logic              inflight_q, inflight_err_q;
    logic [ADDR_W-1:0] last_rd_addr_q;

    assign wr_oor = ({1'b0, wr_addr} >= AddrLimit);
    assign rd_oor = ({1'b0, rd_addr} >= AddrLimit);

    // Outstanding = buffered + the one read whose q arrives this cycle; a same-cycle pop
    // frees a slot in time for the new read to land two cycles later.
    assign pop       = rsp_valid && rsp_ready;
    assign occ       = OccW'(fifo_count) + OccW'(inflight_q);
    assign rd_credit = (occ < OccW'(RSP_DEPTH)) || pop;

    assign elig_wr = wr_valid && !rst;
    assign elig_rd = rd_valid && rd_credit && !rst;

`ifdef SPRAM_CTRL_WR_PRIO_EN
    always_comb begin
        gnt = GNT_NONE;
        if (elig_wr) begin
            gnt = GNT_WR;
        end else if (elig_rd) begin
            gnt = GNT_RD;
        end
    end
`else
    rr_ptr_e rr_ptr_q;
    logic    contested;

    assign contested = elig_wr && elig_rd;

    always_comb begin
        gnt = GNT_NONE;
        if (contested) begin
            gnt = (rr_ptr_q == RrWr) ? GNT_WR : GNT_RD;
        end else if (elig_wr) begin
            gnt = GNT_WR;
        end else if (elig_rd) begin
            gnt = GNT_RD;
        end
    end

    // Only contested grants move the pointer, to the channel that lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= RrWr;
        end else if (contested) begin
            rr_ptr_q <= (gnt == GNT_WR) ? RrRd : RrWr;
        end
    end
`endif

    assign grant_wr = (gnt == GNT_WR);
    assign grant_rd = (gnt == GNT_RD);
    assign wr_ready = grant_wr;
    assign rd_ready = grant_rd;

    // Idle cycles hold the last read address so the RAM output stays quiet.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = last_rd_addr_q;
        ram_data = '0;
        if (grant_wr) begin
            ram_we   = !wr_oor;
            ram_addr = wr_addr;
            ram_data = wr_data;
        end else if (grant_rd) begin
            ram_addr = rd_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q     <= 1'b0;
            inflight_err_q <= 1'b0;
            last_rd_addr_q <= '0;
        end else begin
            inflight_q <= grant_rd;
            if (grant_rd) begin
                inflight_err_q <= rd_oor;
                last_rd_addr_q <= rd_addr;
            end
        end
    end

    // q is valid the cycle after the read issue; capture it then.
    assign push       = inflight_q;
    assign fifo_wdata = {inflight_err_q, (inflight_err_q ? {DATA_W{1'b0}} : ram_q)};

    spram_rsp_fifo #(
        .Depth (RSP_DEPTH),
        .Width (RecW)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (fifo_wdata),
        .pop_i   (pop),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_data  = fifo_empty ? '0 : fifo_rdata[DATA_W-1:0];
    assign rsp_err   = !fifo_empty && fifo_rdata[DATA_W];

    // Credit accounting must make a push into a full FIFO impossible without a pop.
    assert property (@(posedge clk) disable iff (rst) !(push && fifo_full && !pop));
    assert property (@(posedge clk) !(wr_ready && rd_ready));

endmodule

// File: tb/tb_spram_access_ctrl.sv
// Self-checking bench for spram_access_ctrl with a behavioural single-port RAM attached.
// A reference memory is updated on accepted writes; each accepted read pushes its expected
// {err, data} into a scoreboard queue that is popped on every response handshake.
module tb_spram_access_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_addr, wr_data;
    logic       rd_valid, rd_ready;
    logic [7:0] rd_addr;
    logic       rsp_valid, rsp_ready, rsp_err;
    logic [7:0] rsp_data;
    logic [7:0] ram_data, ram_addr, ram_q;
    logic       ram_we;

    int total = 0;
    int bad   = 0;
    int n_rsp = 0;

    logic [8:0] sb [$];
    logic [7:0] ref_mem [64];
    logic [7:0] ram_mem [64];
    logic [7:0] ram_addr_r;

    always #5 clk = ~clk;

    spram_access_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .ram_data  (ram_data),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_q     (ram_q)
    );

    // Single-port RAM: registered read address, combinational q.
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr[5:0]] <= ram_data;
        ram_addr_r <= ram_addr;
    end
    assign ram_q = ram_mem[ram_addr_r[5:0]];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (wr_valid && wr_ready && wr_addr < 8'd64) ref_mem[wr_addr[5:0]] <= wr_data;
            if (rd_valid && rd_ready)
                sb.push_back((rd_addr >= 8'd64) ? 9'h100 : {1'b0, ref_mem[rd_addr[5:0]]});
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check_val("rsp_unexpected", {23'd0, rsp_err, rsp_data}, 32'hDEAD);
                end else begin
                    check_val("rsp", {23'd0, rsp_err, rsp_data}, {23'd0, sb.pop_front()});
                    n_rsp <= n_rsp + 1;
                end
            end
        end
    end

    task automatic write_word(input logic [7:0] a, input logic [7:0] d);
        int g = 0;
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        while (!wr_ready && g < 10) begin @(negedge clk); g++; end
        check_val("wr_rdy", wr_ready, 1);
        check_val("wr_ram", {ram_we, ram_addr, ram_data}, {(a < 8'd64), a, d});
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic read_word(input logic [7:0] a);
        int g = 0;
        rd_valid = 1'b1; rd_addr = a;
        @(negedge clk);
        while (!rd_ready && g < 10) begin @(negedge clk); g++; end
        check_val("rd_rdy", rd_ready, 1);
        check_val("rd_ram", {ram_we, ram_addr}, {1'b0, a});
        @(posedge clk); #1;
        rd_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        rsp_ready = 1'b1;
        while (sb.size() != 0 && g < 50) begin @(posedge clk); g++; end
        #1;
        check_val("drain", sb.size(), 0);
    endtask

    // Offer n reads (addr 0..) with responses blocked, check acceptance pattern, then unblock.
    task automatic credit_probe(input int n, input logic [7:0] pat);
        int idx = 0;
        int g = 0;
        rsp_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            rd_valid = 1'b1; rd_addr = 8'(idx);
            @(negedge clk);
            check_val("credit_rdy", rd_ready, pat[i]);
            if (i >= 2) check_val("hold_rsp", {rsp_valid, rsp_err, rsp_data}, {2'b10, 8'h3C});
            if (rd_ready) idx++;
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        while (idx < n && g < 20) begin
            rd_addr = 8'(idx);
            @(negedge clk);
            if (rd_ready) idx++;
            g++;
            @(posedge clk); #1;
        end
        rd_valid = 1'b0;
        check_val("credit_resume", idx, n);
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        int idx;
        int g;
        int n0;
        logic exp_wr;

        rst = 1'b1; wr_valid = 1'b1; rd_valid = 1'b1;
        wr_addr = '0; wr_data = '0; rd_addr = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_ready", {wr_ready, rd_ready, ram_we}, 0);
        @(posedge clk); #1;
        rst = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
        @(negedge clk);
        check_val("rst_out", {rsp_valid, rsp_err, rsp_data, ram_we, ram_addr}, 0);
        @(posedge clk); #1;

        // Write then read same address; response two cycles after read grant.
        write_word(8'd5, 8'hA5);
        rsp_ready = 1'b1;
        rd_valid = 1'b1; rd_addr = 8'd5;
        @(negedge clk);
        check_val("rd_grant", rd_ready, 1);
        @(posedge clk); #1;
        rd_valid = 1'b0;
        @(negedge clk);
        check_val("lat_t1", rsp_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("lat_t2", {rsp_valid, rsp_err, rsp_data}, {2'b10, 8'hA5});
        @(posedge clk); #1;
        drain();

        // Contested arbitration over 6 cycles.
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1; wr_addr = 8'(10 + i); wr_data = 8'(i * 17);
            rd_valid = 1'b1; rd_addr = 8'd5;
`ifdef SPRAM_CTRL_WR_PRIO_EN
            exp_wr = 1'b1;
`else
            exp_wr = (i % 2 == 0);
`endif
            @(negedge clk);
            check_val("arb_wr", wr_ready, exp_wr);
            check_val("arb_rd", rd_ready, !exp_wr);
            @(posedge clk); #1;
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
        drain();

        for (int a = 0; a < 16; a++) write_word(8'(a), 8'(a) ^ 8'h3C);

        // Credit limit with responses blocked.
        credit_probe(4, 8'b0011);

        // Out-of-range read and write.
        rsp_ready = 1'b1;
        read_word(8'd70);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("oor_rsp", {rsp_valid, rsp_err, rsp_data}, {2'b11, 8'h00});
        @(posedge clk); #1;
        write_word(8'd64, 8'hFF);
        read_word(8'd0);
        drain();

        // Reset one cycle after a read grant.
        rd_valid = 1'b1; rd_addr = 8'd1;
        @(negedge clk);
        check_val("pre_rst_rd", rd_ready, 1);
        @(posedge clk); #1;
        rst = 1'b1; rd_valid = 1'b0; wr_valid = 1'b1; wr_addr = 8'd3;
        @(negedge clk);
        check_val("mid_rst_ready", {wr_ready, rd_ready, ram_we}, 0);
        @(posedge clk); #1;
        rst = 1'b0; wr_valid = 1'b0;
        @(negedge clk);
        check_val("post_rst_out", {rsp_valid, rsp_err, rsp_data, ram_we, ram_addr}, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("no_ghost", rsp_valid, 0);
            @(posedge clk); #1;
        end
        credit_probe(3, 8'b011);

        // Streaming reads with rsp_ready toggling.
        idx = 0; g = 0; n0 = n_rsp;
        while (idx < 16 && g < 200) begin
            rsp_ready = (g % 2 == 1);
            rd_valid = 1'b1; rd_addr = 8'(idx);
            @(negedge clk);
            if (rd_ready) idx++;
            g++;
            @(posedge clk); #1;
        end
        rd_valid = 1'b0;
        check_val("stream_issued", idx, 16);
        drain();
        @(negedge clk);
        check_val("stream_count", n_rsp - n0, 16);
        check_val("stream_idle", rsp_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
